// File: rtl/vga_sync_gen.sv
// vga_sync_gen: single-axis VGA timing generator sequencing sync, back porch, active and front porch
// with tick gating, programmable sync polarity, pixel indexing and synchronous restart.
module vga_sync_gen #(
  parameter int CNT_W    = 12,
  parameter int SYNC_LEN = 384,
  parameter int BP_LEN   = 192,
  parameter int ACT_LEN  = 2560,
  parameter int FP_LEN   = 64,
  parameter int DIV      = 4,
  parameter int PIX_W    = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             restart,
  output logic             sync,
  output logic             active,
  output logic [PIX_W-1:0] pix_idx,
  output logic             period_end
);
  localparam int SUB_W = DIV > 1 ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {SYNC_S, BP_S, ACT_S, FP_S} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_last;
  logic [SUB_W-1:0] sub, sub_nxt;
  logic [PIX_W-1:0] pix_nxt;
  logic adv, stay_act, sub_wrap, sync_nxt, active_nxt, period_end_nxt;
  assign cnt_last = state == SYNC_S ? CNT_W'(SYNC_LEN - 1) :
                    state == BP_S   ? CNT_W'(BP_LEN - 1)   :
                    state == ACT_S  ? CNT_W'(ACT_LEN - 1)  : CNT_W'(FP_LEN - 1);
  assign adv = tick && cnt == cnt_last;
  // pixel counters only run while remaining in ACT; any exit or entry zeroes them
  assign stay_act = state == ACT_S && !restart && !adv;
  assign sub_wrap = sub == SUB_W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= SYNC_S;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (restart) state_nxt = SYNC_S;
    else if (adv) state_nxt = state == SYNC_S ? BP_S : state == BP_S ? ACT_S : state == ACT_S ? FP_S : SYNC_S;
    cnt_nxt = restart ? '0 : !tick ? cnt : adv ? '0 : cnt + 1'b1;
  end
  always_comb begin
    sync_nxt       = state_nxt == SYNC_S ? SYNC_POL : ~SYNC_POL;
    active_nxt     = state_nxt == ACT_S;
    period_end_nxt = !restart && adv && state == FP_S;
    sub_nxt        = !stay_act ? '0 : !tick ? sub : sub_wrap ? '0 : sub + 1'b1;
    pix_nxt        = !stay_act ? '0 : (tick && sub_wrap) ? pix_idx + 1'b1 : pix_idx;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt        <= '0;
      sub        <= '0;
      pix_idx    <= '0;
      sync       <= SYNC_POL;
      active     <= 1'b0;
      period_end <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      sub        <= sub_nxt;
      pix_idx    <= pix_nxt;
      sync       <= sync_nxt;
      active     <= active_nxt;
      period_end <= period_end_nxt;
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: default instance, a small instance and a cascaded vertical instance,
// checked every cycle against a tick-position model of the period.
module tb_vga_sync_gen;
  logic clk = 0, reset = 1, tick_a = 0, restart_a = 0, tick_b = 0, restart_b = 0;
  logic sync_a, active_a, pe_a;
  logic [9:0] pix_a;
  logic sync_s, active_s, pe_s;
  logic [3:0] pix_s;
  logic sync_v, active_v, pe_v;
  logic [3:0] pix_v;
  int checks = 0, errors = 0;
  int m_pos_a = 0, m_pos_b = 0, m_pos_v = 0;
  bit m_pe_a = 0, m_pe_b = 0, m_pe_v = 0;
  logic [38:0] got_all, exp_all;
  logic [38:0] rst_exp = {1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 10'd0, 1'b0, 13'd0};

  always #5 clk = ~clk;

  vga_sync_gen dut (.clk(clk), .reset(reset), .tick(tick_a), .restart(restart_a),
    .sync(sync_a), .active(active_a), .pix_idx(pix_a), .period_end(pe_a));
  vga_sync_gen #(.CNT_W(4), .SYNC_LEN(2), .BP_LEN(3), .ACT_LEN(4), .FP_LEN(1), .DIV(1), .PIX_W(4), .SYNC_POL(1'b1))
    dut_s (.clk(clk), .reset(reset), .tick(tick_b), .restart(restart_b),
    .sync(sync_s), .active(active_s), .pix_idx(pix_s), .period_end(pe_s));
  vga_sync_gen #(.CNT_W(4), .SYNC_LEN(1), .BP_LEN(1), .ACT_LEN(2), .FP_LEN(1), .DIV(1), .PIX_W(4), .SYNC_POL(1'b0))
    dut_v (.clk(clk), .reset(reset), .tick(pe_s), .restart(restart_b),
    .sync(sync_v), .active(active_v), .pix_idx(pix_v), .period_end(pe_v));

  function automatic logic [12:0] expv(int pos, int s, int b, int a, int div, bit pol, bit pe);
    bit act = pos >= s + b && pos < s + b + a;
    int pix = act ? (pos - s - b) / div : 0;
    return {pos < s ? pol : ~pol, act, 10'(pix), pe};
  endfunction

  assign got_all = {sync_a, active_a, pix_a, pe_a, sync_s, active_s, 6'd0, pix_s, pe_s,
                    sync_v, active_v, 6'd0, pix_v, pe_v};
  assign exp_all = {expv(m_pos_a, 384, 192, 2560, 4, 1'b0, m_pe_a),
                    expv(m_pos_b, 2, 3, 4, 1, 1'b1, m_pe_b),
                    expv(m_pos_v, 1, 1, 2, 1, 1'b0, m_pe_v)};

  // model: position in ticks since period start; the vertical axis ticks on the modelled line end
  always @(posedge clk or negedge reset)
    if (!reset) begin
      m_pos_a <= 0; m_pos_b <= 0; m_pos_v <= 0;
      m_pe_a <= 0; m_pe_b <= 0; m_pe_v <= 0;
    end else begin
      m_pe_a  <= !restart_a && tick_a && m_pos_a == 3199;
      m_pos_a <= restart_a ? 0 : tick_a ? (m_pos_a + 1) % 3200 : m_pos_a;
      m_pe_b  <= !restart_b && tick_b && m_pos_b == 9;
      m_pos_b <= restart_b ? 0 : tick_b ? (m_pos_b + 1) % 10 : m_pos_b;
      m_pe_v  <= !restart_b && m_pe_b && m_pos_v == 4;
      m_pos_v <= restart_b ? 0 : m_pe_b ? (m_pos_v + 1) % 5 : m_pos_v;
    end

  task automatic test_reset();
    #2 reset = 0;
    #1 checks++;
    if (got_all !== rst_exp) begin errors++; $display("FAIL reset_async got %h exp %h", got_all, rst_exp); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got_all !== rst_exp) begin errors++; $display("FAIL reset_held got %h exp %h", got_all, rst_exp); end
    reset = 1;
  endtask

  task automatic test_full_period();
    int act_n = 0, pe_n = 0;
    tick_a = 1;
    for (int i = 0; i < 3210; i++) begin
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL full_period cyc %0d got %h exp %h", i, got_all, exp_all); end
      act_n += int'(active_a);
      pe_n += int'(pe_a);
    end
    checks++;
    if (act_n != 2560) begin errors++; $display("FAIL active_len got %0d exp 2560", act_n); end
    checks++;
    if (pe_n != 1) begin errors++; $display("FAIL period_end_count got %0d exp 1", pe_n); end
  endtask

  task automatic test_small_cascade();
    int act_v = 0, last_pe = -1, pe_n = 0;
    restart_b = 1;
    tick_b = 1;
    @(negedge clk);
    restart_b = 0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL small_cascade cyc %0d got %h exp %h", i, got_all, exp_all); end
      act_v += int'(active_v);
      if (pe_v) begin
        pe_n++;
        if (last_pe >= 0) begin
          checks++;
          if (i - last_pe != 50) begin errors++; $display("FAIL v_period got %0d exp 50", i - last_pe); end
        end
        last_pe = i;
      end
    end
    checks++;
    if (act_v != 40) begin errors++; $display("FAIL v_active_cycles got %0d exp 40", act_v); end
    checks++;
    if (pe_n != 2) begin errors++; $display("FAIL v_pe_count got %0d exp 2", pe_n); end
  endtask

  task automatic test_restart();
    int n = 0;
    bit found = 0;
    tick_a = 1;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL restart_pre got %h exp %h", got_all, exp_all); end
      found = m_pos_a == 976;
    end
    checks++;
    if (!found || pix_a !== 10'd100) begin errors++; $display("FAIL restart_wait found %0d pix %0d exp 100", found, pix_a); end
    restart_a = 1;
    @(negedge clk);
    restart_a = 0;
    checks++;
    if ({sync_a, active_a, pix_a, pe_a} !== 13'd0) begin
      errors++; $display("FAIL restart_out got %b%b %0d %b exp 00 0 0", sync_a, active_a, pix_a, pe_a);
    end
    found = 0;
    while (!found && n < 3300) begin
      @(negedge clk);
      n++;
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL restart_post cyc %0d got %h exp %h", n, got_all, exp_all); end
      found = pe_a;
    end
    checks++;
    if (n != 3200) begin errors++; $display("FAIL restart_period got %0d exp 3200", n); end
  endtask

  task automatic test_reset_mid();
    int first_sync = -1;
    bit found = 0;
    tick_a = 1;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(negedge clk);
      found = m_pos_a == 400;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_wait got 0 exp 1"); end
    #2 reset = 0;
    #1 checks++;
    if (got_all !== rst_exp) begin errors++; $display("FAIL reset_mid_async got %h exp %h", got_all, rst_exp); end
    repeat (2) @(negedge clk);
    checks++;
    if (got_all !== rst_exp) begin errors++; $display("FAIL reset_mid_held got %h exp %h", got_all, rst_exp); end
    reset = 1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL reset_mid_post cyc %0d got %h exp %h", i, got_all, exp_all); end
      if (sync_a && first_sync < 0) first_sync = i;
    end
    checks++;
    if (first_sync != 383) begin errors++; $display("FAIL sync_edge got %0d exp 383", first_sync); end
  endtask

  task automatic test_tick_gap();
    int last_pe = -1, n_int = 0;
    for (int i = 0; i < 25700; i++) begin
      tick_a = (i % 4 == 3);
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL tick_gap cyc %0d got %h exp %h", i, got_all, exp_all); end
      if (pe_a) begin
        if (last_pe >= 0) begin
          n_int++;
          checks++;
          if (i - last_pe != 12800) begin errors++; $display("FAIL gap_period got %0d exp 12800", i - last_pe); end
        end
        last_pe = i;
      end
    end
    checks++;
    if (n_int == 0) begin errors++; $display("FAIL gap_intervals got 0 exp >0"); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      tick_a = 1'($urandom_range(0, 1));
      tick_b = $urandom_range(0, 2) != 0;
      restart_a = $urandom_range(0, 499) == 0;
      restart_b = $urandom_range(0, 99) == 0;
      @(negedge clk);
      checks++;
      if (got_all !== exp_all) begin errors++; $display("FAIL random cyc %0d got %h exp %h", i, got_all, exp_all); end
    end
    restart_a = 0;
    restart_b = 0;
  endtask

  initial begin
    test_reset();
    test_full_period();
    test_small_cascade();
    test_restart();
    test_reset_mid();
    test_tick_gap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Parametrised single-axis VGA sync timing generator. It sequences sync pulse, back porch, active display and front porch, each lasting a configurable number of advance ticks. It also produces a display-enable signal, a divided pixel/line index, and a one-cycle period-end strobe. Two instances cascade into a full VGA timing core: the horizontal instance's `period_end` drives the vertical instance's `tick`. The block replaces fixed-count hsync/vsync controllers and adds tick gating, programmable sync polarity, pixel indexing and synchronous restart.

## Interface
- `CNT_W`, 12: phase counter width; must hold max(`SYNC_LEN`,`BP_LEN`,`ACT_LEN`,`FP_LEN`)-1.
- `SYNC_LEN`, 384: sync pulse length in ticks (≥1).
- `BP_LEN`, 192: back porch length in ticks (≥1).
- `ACT_LEN`, 2560: active region length in ticks (≥1, multiple of `DIV`).
- `FP_LEN`, 64: front porch length in ticks (≥1).
- `DIV`, 4: ticks per pixel/line index step (≥1).
- `PIX_W`, 10: index width; must hold `ACT_LEN`/`DIV`-1.
- `SYNC_POL`, 0: level of `sync` during the sync phase; the opposite level applies elsewhere.

- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: advance enable; the FSM and counters move only on edges where `tick`=1.
- `restart` input 1: synchronous; forces start of the sync phase; priority over `tick`.
- `sync` output 1: sync pulse, polarity per `SYNC_POL`.
- `active` output 1: high during the active phase.
- `pix_idx` output `PIX_W`: index within the active region; 0 outside it.
- `period_end` output 1: one-cycle strobe when the front porch completes.

## Operation
- FSM states: SYNC → BP → ACT → FP → SYNC. 2-bit encoding; unreachable codes recover to SYNC.
- Phase counter `cnt` runs 0..LEN-1 of the current state.
  - On a tick with `cnt`=LEN-1: advance state and set `cnt`=0.
  - On any other tick: `cnt`+1.
  - No tick: hold everything.
- All outputs are registered (Moore); no combinational path from inputs to outputs.
  - `sync` = `SYNC_POL` in SYNC, otherwise ~`SYNC_POL`.
  - `active` = (state==ACT).
- Pixel index:
  - Sub-counter `sub` runs 0..DIV-1 and advances on ticks in ACT only.
  - On a tick with `sub`=DIV-1: `pix_idx`+1 and `sub`=0.
  - Entering ACT sets `pix_idx`=0 and `sub`=0; leaving ACT sets `pix_idx`=0.
  - Within ACT, `pix_idx` = floor(`cnt`/`DIV`), range 0..ACT_LEN/DIV-1. It never wraps inside ACT.
- `period_end`:
  - Set for exactly one cycle by the tick edge that leaves FP; it coincides with the first cycle of the new SYNC.
  - Cleared on the next edge, regardless of `tick`.
- `restart`=1 at an edge: state=SYNC, `cnt`=0, `sub`=0, `pix_idx`=0, `period_end`=0. `tick` is ignored on that edge.
- Reset (`reset`=0, immediate, any point mid-operation): state=SYNC, all counters 0, `sync`=`SYNC_POL`, `active`=0, `pix_idx`=0, `period_end`=0.
- Cascade: a vertical instance with `tick`=horizontal `period_end` advances exactly once per line.

## Timing
- Period = SYNC_LEN+BP_LEN+ACT_LEN+FP_LEN ticks. Defaults give 3200 ticks.
- Each phase lasts exactly LEN ticks; outputs change on the edge following the tick that ends the phase.
- With `tick` held high, edges are counted from the first rising edge after reset release as edge 1:
  - `sync` changes after edge 384.
  - `active` is high from after edge 576 through edge 3136.
  - `period_end` is high for the cycle after edge 3200.
- Latency from input to output: 1 clock.
- `tick` gaps stretch every phase proportionally; no tick is lost or double-counted.

## Test plan
- Defaults, `tick`=1 → `sync`=0 for 384 cycles then 1; `active` high for 2560 cycles starting at cycle 577; `pix_idx` steps every 4 cycles 0..639, then 0; `period_end` pulses once, width 1, every 3200 cycles.
- `tick`=1 every 4th cycle → all durations ×4; period 12800 cycles; `period_end` still 1 cycle wide.
- `restart` pulsed while `pix_idx`=100 in ACT → next cycle `sync`=0, `active`=0, `pix_idx`=0; the following period is exactly 3200 cycles.
- `reset` driven low mid-BP for 2 cycles → outputs take reset values immediately, without waiting for a clock; timing restarts from SYNC after release.
- `SYNC_POL`=1, `SYNC_LEN`=2, `BP_LEN`=3, `ACT_LEN`=4, `FP_LEN`=1, `DIV`=1 → `sync` high for 2 cycles, `pix_idx` 0,1,2,3, period 10 cycles.
- Cascade: horizontal {2,3,4,1} feeding vertical {1,1,2,1} via `period_end` → vertical `active` high for exactly 2 lines (20 cycles); vertical `period_end` every 50 cycles.
